sd_fifo_rx_filler: RTL and testbench
====================================

Name: sd_fifo_rx_filler

Overview:
Receive-direction counterpart of the TX filler. It buffers 32-bit words pushed by the SD data path into an internal single-clock FIFO. It drains those words to system memory as a Wishbone classic master, writing to sequential addresses starting at adr. It sits between the SD data receiver and the system Wishbone bus.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 words
ADR_STEP, 4, byte increment of the bus address after each acknowledged write

Ports:
clk  in  1  system clock; clocks all logic
rst  in  1  synchronous reset, active-high
m_wb_adr_o  out  32  Wishbone address = adr + offset
m_wb_we_o  out  1  write enable; high whenever m_wb_cyc_o is high
m_wb_dat_o  out  32  write data
m_wb_cyc_o  out  1  bus cycle
m_wb_stb_o  out  1  strobe; equal to m_wb_cyc_o
m_wb_ack_i  in  1  slave acknowledge
m_wb_cti_o  out  3  constant 3'b000 (classic cycle)
m_wb_bte_o  out  2  constant 2'b00
en  in  1  transfer enable; low clears the offset once the FSM is idle
adr  in  32  base byte address of the destination buffer
dat_i  in  32  word from the SD receiver
wr  in  1  push strobe for dat_i, one word per cycle
full  out  1  FIFO holds 2**FIFO_AW words
fe  out  1  FIFO empty
ovf  out  1  sticky overflow: a wr arrived while full was high

Behaviour:
- Reset (rst sampled high):
  - FIFO pointers and count = 0; fe=1, full=0, ovf=0.
  - FSM = IDLE; cyc, stb and we = 0.
  - m_wb_dat_o = 0, offset = 0, so m_wb_adr_o = adr.
  - A reset in the middle of a transfer drops cyc in the next cycle with no handshake, and all FIFO data is discarded.
- FIFO:
  - Registered count, read pointer and write pointer.
  - wr while !full stores dat_i at the write pointer; the pointer wraps modulo depth.
  - wr while full drops the word and sets ovf.
  - Push and pop in the same cycle leave the count unchanged. A push into an empty FIFO cannot be popped in that same cycle.
  - full and fe are decoded from the registered count.
- ovf stays set until rst, or until en is low while the FSM is IDLE.
- FSM has two states, IDLE and BUS.
  - IDLE -> BUS when en=1 and count!=0. On that edge:
    - latch the FIFO head into m_wb_dat_o and pop it;
    - set cyc=stb=we=1.
  - BUS holds all outputs stable until m_wb_ack_i=1. On the ack edge:
    - cyc, stb and we go to 0;
    - offset += ADR_STEP, modulo 2**32;
    - FSM -> IDLE.
  - Mandatory one idle cycle between bus cycles. With a zero-wait slave, throughput is one word per 2 clocks.
  - If en falls while in BUS, the current cycle still completes on ack, and no new cycle starts afterwards.
  - ack while in IDLE is ignored.
- m_wb_adr_o = adr + offset, combinational. adr must be held stable while en=1.
- Latency: a word pushed at edge k gives cyc=1 after edge k+1, if the FSM is IDLE and en=1.

Decomposition:
- Shared package sd_rx_filler_pkg holds:
  - state enum (IDLE, BUS);
  - CTI_CLASSIC = 3'b000 and BTE_LINEAR = 2'b00;
  - default ADR_STEP.
- One sub-module, sd_rx_sync_fifo: the parameterised single-clock FIFO with count, full and fe.
- The top module holds the FSM, offset counter, ovf flag and bus outputs.

Test Plan:
1. Reset, then idle with en=0 → cyc=0, fe=1, full=0, ovf=0, m_wb_adr_o = adr; holds for 10 cycles.
2. en=1, adr=0x1000; push 0xA5A5_0001 and 0xA5A5_0002; slave acks the cycle after stb → two writes:
   - adr 0x1000 with data 0xA5A5_0001;
   - adr 0x1004 with data 0xA5A5_0002;
   - one cycle of cyc=0 between them; fe=1 afterwards.
3. en=0; push 9 words 0..8 back-to-back → full=1 after the 8th push; ovf=1 after the 9th; no bus activity. Then en=1 → 8 writes of data 0..7 at 0x1000..0x101C; word 8 is never written.
4. Slave holds ack low for 5 cycles → adr, dat, cyc, stb and we remain stable for those 5 cycles; offset advances only on ack.
5. en falls in BUS with 3 words queued → the current write completes on ack and no further cycle starts. Offset returns to 0 in IDLE, and with en=1 the remaining 2 words go to adr and adr+4.
6. rst asserted in BUS with 4 words queued → cyc=0, fe=1 and offset=0 the next cycle; no ack is required.

Source files
------------

// File: rtl/sd_rx_filler_pkg.sv
// rtl/sd_rx_filler_pkg.sv - shared types and constants for the SD receive-side FIFO filler
package sd_rx_filler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  localparam logic [2:0] CTI_CLASSIC      = 3'b000;
  localparam logic [1:0] BTE_LINEAR       = 2'b00;
  localparam int         ADR_STEP_DEFAULT = 4;

endpackage

// File: rtl/sd_rx_sync_fifo.sv
// rtl/sd_rx_sync_fifo.sv - single-clock FIFO with registered count, full and empty flags
module sd_rx_sync_fifo #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          fe
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          do_push;
  logic          do_pop;

  // Pop only sees registered contents, so a word pushed this cycle is not yet poppable.
  assign do_push = push && !full;
  assign do_pop  = pop && !fe;

  assign full = (count == (AW+1)'(DEPTH));
  assign fe   = (count == '0);
  assign dout = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sd_fifo_rx_filler.sv
// rtl/sd_fifo_rx_filler.sv - buffers SD receive words and writes them to memory as a Wishbone classic master
module sd_fifo_rx_filler
  import sd_rx_filler_pkg::*;
#(
  parameter int FIFO_AW  = 3,
  parameter int ADR_STEP = ADR_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] m_wb_adr_o,
  output logic        m_wb_we_o,
  output logic [31:0] m_wb_dat_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  input  logic        m_wb_ack_i,
  output logic [2:0]  m_wb_cti_o,
  output logic [1:0]  m_wb_bte_o,
  input  logic        en,
  input  logic [31:0] adr,
  input  logic [31:0] dat_i,
  input  logic        wr,
  output logic        full,
  output logic        fe,
  output logic        ovf
);

  state_t         state_q;
  state_t         state_d;
  logic           pop;
  logic [31:0]    head;
  logic [FIFO_AW:0] count;
  logic [31:0]    dat_q;
  logic [31:0]    offset_q;
  logic           ovf_q;
  logic           idle_clear;

  sd_rx_sync_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .pop   (pop),
    .din   (dat_i),
    .dout  (head),
    .count (count),
    .full  (full),
    .fe    (fe)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (count != '0)) begin
          state_d = BUS;
          pop     = 1'b1;
        end
      end
      BUS: begin
        if (m_wb_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle_clear = (state_q == IDLE) && !en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dat_q    <= '0;
      offset_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        dat_q <= head;
      end
      if ((state_q == BUS) && m_wb_ack_i) begin
        offset_q <= offset_q + 32'(ADR_STEP);
      end else if (idle_clear) begin
        offset_q <= '0;
      end
      // A dropped word wins over a same-cycle clear so the loss is never hidden.
      if (wr && full) begin
        ovf_q <= 1'b1;
      end else if (idle_clear) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign m_wb_cyc_o = (state_q == BUS);
  assign m_wb_stb_o = m_wb_cyc_o;
  assign m_wb_we_o  = m_wb_cyc_o;
  assign m_wb_dat_o = dat_q;
  assign m_wb_adr_o = adr + offset_q;
  assign m_wb_cti_o = CTI_CLASSIC;
  assign m_wb_bte_o = BTE_LINEAR;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_sd_fifo_rx_filler.sv
// tb/tb_sd_fifo_rx_filler.sv - directed self-checking bench for sd_fifo_rx_filler
module tb_sd_fifo_rx_filler;

  logic        clk;
  logic        rst;
  logic [31:0] m_wb_adr_o;
  logic        m_wb_we_o;
  logic [31:0] m_wb_dat_o;
  logic        m_wb_cyc_o;
  logic        m_wb_stb_o;
  logic        m_wb_ack_i;
  logic [2:0]  m_wb_cti_o;
  logic [1:0]  m_wb_bte_o;
  logic        en;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic        wr;
  logic        full;
  logic        fe;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq_adr[$];
  logic [31:0] wq_dat[$];
  int          len_q[$];
  int          start_q[$];

  int          ack_wait = 0;
  int          cycle_cnt = 0;
  int          cur_len = 0;
  bit          in_cyc = 0;
  logic [31:0] s_adr;
  logic [31:0] s_dat;

  sd_fifo_rx_filler dut (
    .clk        (clk),
    .rst        (rst),
    .m_wb_adr_o (m_wb_adr_o),
    .m_wb_we_o  (m_wb_we_o),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_cyc_o (m_wb_cyc_o),
    .m_wb_stb_o (m_wb_stb_o),
    .m_wb_ack_i (m_wb_ack_i),
    .m_wb_cti_o (m_wb_cti_o),
    .m_wb_bte_o (m_wb_bte_o),
    .en         (en),
    .adr        (adr),
    .dat_i      (dat_i),
    .wr         (wr),
    .full       (full),
    .fe         (fe),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave and monitor: samples on the falling edge, acks after ack_wait stalled cycles.
  always @(negedge clk) begin
    cycle_cnt++;
    if (m_wb_cyc_o) begin
      if (!in_cyc) begin
        in_cyc  = 1;
        s_adr   = m_wb_adr_o;
        s_dat   = m_wb_dat_o;
        cur_len = 0;
        start_q.push_back(cycle_cnt);
      end else begin
        check("stable_adr", m_wb_adr_o, s_adr);
        check("stable_dat", m_wb_dat_o, s_dat);
      end
      check("stb_eq_cyc", {31'b0, m_wb_stb_o}, 32'd1);
      check("we_eq_cyc", {31'b0, m_wb_we_o}, 32'd1);
      cur_len++;
      if (cur_len > ack_wait) begin
        m_wb_ack_i = 1'b1;
        wq_adr.push_back(m_wb_adr_o);
        wq_dat.push_back(m_wb_dat_o);
      end
    end else begin
      if (in_cyc) len_q.push_back(cur_len);
      in_cyc     = 0;
      m_wb_ack_i = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    wr    = 1'b1;
    dat_i = d;
    tick();
    wr    = 1'b0;
  endtask

  task automatic clear_log();
    wq_adr.delete();
    wq_dat.delete();
    len_q.delete();
    start_q.delete();
  endtask

  task automatic wait_writes(input int n, input string tag);
    for (int i = 0; i < 300 && wq_adr.size() < n; i++) tick();
    check(tag, wq_adr.size(), n);
    for (int i = 0; i < 300 && (m_wb_cyc_o || !fe); i++) tick();
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    adr        = 32'h0000_1000;
    dat_i      = '0;
    wr         = 1'b0;
    m_wb_ack_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      check("rst_cyc", {31'b0, m_wb_cyc_o}, 32'd0);
      check("rst_fe", {31'b0, fe}, 32'd1);
      check("rst_full", {31'b0, full}, 32'd0);
      check("rst_ovf", {31'b0, ovf}, 32'd0);
      check("rst_adr", m_wb_adr_o, 32'h0000_1000);
      tick();
    end
    check("cti", {29'b0, m_wb_cti_o}, 32'd0);
    check("bte", {30'b0, m_wb_bte_o}, 32'd0);

    // 2: two words, zero-wait slave
    clear_log();
    en = 1'b1;
    push_word(32'hA5A5_0001);
    push_word(32'hA5A5_0002);
    wait_writes(2, "t2_count");
    if (wq_adr.size() == 2 && len_q.size() == 2) begin
      check("t2_adr0", wq_adr[0], 32'h0000_1000);
      check("t2_dat0", wq_dat[0], 32'hA5A5_0001);
      check("t2_adr1", wq_adr[1], 32'h0000_1004);
      check("t2_dat1", wq_dat[1], 32'hA5A5_0002);
      check("t2_gap", start_q[1] - (start_q[0] + len_q[0]), 32'd1);
    end
    check("t2_fe", {31'b0, fe}, 32'd1);

    // 3: fill to overflow with en low, then drain
    en = 1'b0;
    tick();
    clear_log();
    check("t3_offset_clr", m_wb_adr_o, 32'h0000_1000);
    for (int i = 0; i < 9; i++) begin
      push_word(i);
      if (i == 7) begin
        check("t3_full8", {31'b0, full}, 32'd1);
        check("t3_ovf8", {31'b0, ovf}, 32'd0);
      end
    end
    check("t3_ovf9", {31'b0, ovf}, 32'd1);
    check("t3_full9", {31'b0, full}, 32'd1);
    tick();
    tick();
    check("t3_no_bus", wq_adr.size(), 32'd0);
    en = 1'b1;
    wait_writes(8, "t3_count");
    for (int i = 0; i < 8 && i < wq_adr.size(); i++) begin
      check("t3_adr", wq_adr[i], 32'h0000_1000 + 4 * i);
      check("t3_dat", wq_dat[i], i);
    end
    check("t3_no_word8", wq_adr.size(), 32'd8);

    // 4: slave stalls 5 cycles
    clear_log();
    ack_wait = 5;
    push_word(32'h4444_0004);
    wait_writes(1, "t4_count");
    if (wq_adr.size() == 1 && len_q.size() == 1) begin
      check("t4_len", len_q[0], 32'd6);
      check("t4_adr", wq_adr[0], 32'h0000_1020);
      check("t4_dat", wq_dat[0], 32'h4444_0004);
    end
    check("t4_offset_after", m_wb_adr_o, 32'h0000_1024);

    // 5: en falls during a bus cycle with words queued
    clear_log();
    ack_wait = 3;
    push_word(32'hC0C0_0001);
    push_word(32'hC0C0_0002);
    en = 1'b0;
    check("t5_in_bus", {31'b0, m_wb_cyc_o}, 32'd1);
    push_word(32'hC0C0_0003);
    for (int i = 0; i < 100 && wq_adr.size() < 1; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    check("t5_one_write", wq_adr.size(), 32'd1);
    if (wq_adr.size() >= 1) begin
      check("t5_adr0", wq_adr[0], 32'h0000_1024);
      check("t5_dat0", wq_dat[0], 32'hC0C0_0001);
    end
    check("t5_idle", {31'b0, m_wb_cyc_o}, 32'd0);
    check("t5_offset0", m_wb_adr_o, 32'h0000_1000);
    check("t5_not_empty", {31'b0, fe}, 32'd0);
    ack_wait = 0;
    en = 1'b1;
    wait_writes(3, "t5_count");
    if (wq_adr.size() == 3) begin
      check("t5_adr1", wq_adr[1], 32'h0000_1000);
      check("t5_dat1", wq_dat[1], 32'hC0C0_0002);
      check("t5_adr2", wq_adr[2], 32'h0000_1004);
      check("t5_dat2", wq_dat[2], 32'hC0C0_0003);
    end

    // 6: reset in the middle of a bus cycle
    clear_log();
    ack_wait = 20;
    for (int i = 0; i < 4; i++) push_word(32'hD000_0000 + i);
    check("t6_in_bus", {31'b0, m_wb_cyc_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_cyc", {31'b0, m_wb_cyc_o}, 32'd0);
    check("t6_fe", {31'b0, fe}, 32'd1);
    check("t6_offset", m_wb_adr_o, 32'h0000_1000);
    check("t6_dat", m_wb_dat_o, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("t6_no_write", wq_adr.size(), 32'd0);
    check("t6_still_idle", {31'b0, m_wb_cyc_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
